// File: rtl/i2c_switch_responder.sv
// I2C target emulating an ADG715 analog switch: one 8-bit switch register,
// written and read back over a synchronized, glitch-filtered SCL/SDA pair.
module i2c_switch_responder #(
    parameter logic [4:0]  BASE_ADDR   = 5'b10010,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3,
    parameter logic [7:0]  RESET_STATE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [1:0] addr_pins,
    output logic [7:0] switch_state,
    output logic       write_strobe,
    output logic       busy
);

    localparam int unsigned CntW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAckW,
        StAckR,
        StWrData,
        StRdData,
        StIgnore
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_s, sda_s;
    logic [CntW-1:0]        scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic                   scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic                   scl_rise, scl_fall, start_evt, stop_evt;

    state_e     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_q;
    logic       ack_drv;
    logic [2:0] rd_idx;
    logic [6:0] dev_addr;

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign dev_addr = {BASE_ADDR, addr_pins};
    assign rd_idx   = 3'd7 - bit_cnt[2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_f_q    <= 1'b1;
            sda_f_q    <= 1'b1;
        end else begin
            scl_sync_q <= (scl_sync_q << 1) | SYNC_STAGES'(scl_in);
            sda_sync_q <= (sda_sync_q << 1) | SYNC_STAGES'(sda_in);
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_f_q    <= scl_f_d;
            sda_f_q    <= sda_f_d;
        end
    end

    // A filtered line flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        scl_f_d   = scl_f_q;
        scl_cnt_d = '0;
        if (scl_s != scl_f_q) begin
            if (scl_cnt_q == CntW'(FILTER_LEN - 1)) begin
                scl_f_d = scl_s;
            end else begin
                scl_cnt_d = scl_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        sda_f_d   = sda_f_q;
        sda_cnt_d = '0;
        if (sda_s != sda_f_q) begin
            if (sda_cnt_q == CntW'(FILTER_LEN - 1)) begin
                sda_f_d = sda_s;
            end else begin
                sda_cnt_d = sda_cnt_q + 1'b1;
            end
        end
    end

    // Events come from the filter's next state so the FSM reacts on the flip edge.
    assign scl_rise  = scl_f_d & ~scl_f_q;
    assign scl_fall  = ~scl_f_d & scl_f_q;
    assign start_evt = ~sda_f_d & sda_f_q & scl_f_q & scl_f_d;
    assign stop_evt  = sda_f_d & ~sda_f_q & scl_f_q & scl_f_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= StIdle;
            busy         <= 1'b0;
            sda_oe       <= 1'b0;
            switch_state <= RESET_STATE;
            write_strobe <= 1'b0;
            bit_cnt      <= '0;
            shift_q      <= '0;
            ack_drv      <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            if (stop_evt) begin
                state   <= StIdle;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
                ack_drv <= 1'b0;
                bit_cnt <= '0;
            end else if (start_evt) begin
                state   <= StAddr;
                busy    <= 1'b1;
                sda_oe  <= 1'b0;
                ack_drv <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    StIdle: ;
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_f_d};
                            if (bit_cnt == 4'd7) begin
                                bit_cnt <= '0;
                                if (shift_q[6:0] == dev_addr) begin
                                    state <= sda_f_d ? StAckR : StAckW;
                                end else begin
                                    state <= StIgnore;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    StAckW, StAckR: begin
                        if (scl_fall) begin
                            if (!ack_drv) begin
                                sda_oe  <= 1'b1;
                                ack_drv <= 1'b1;
                            end else begin
                                ack_drv <= 1'b0;
                                bit_cnt <= '0;
                                if (state == StAckW) begin
                                    sda_oe <= 1'b0;
                                    state  <= StWrData;
                                end else begin
                                    shift_q <= switch_state;
                                    sda_oe  <= ~switch_state[7];
                                    state   <= StRdData;
                                end
                            end
                        end
                    end
                    StWrData: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_f_d};
                            if (bit_cnt == 4'd7) begin
                                switch_state <= {shift_q[6:0], sda_f_d};
                                write_strobe <= 1'b1;
                                bit_cnt      <= '0;
                                state        <= StAckW;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    StRdData: begin
                        // bit_cnt counts controller sample edges; 8 means the ACK slot.
                        if (scl_rise) begin
                            if (bit_cnt == 4'd8) begin
                                if (!sda_f_d) begin
                                    shift_q <= switch_state;
                                    bit_cnt <= '0;
                                end else begin
                                    state <= StIgnore;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end else if (scl_fall) begin
                            sda_oe <= (bit_cnt == 4'd8) ? 1'b0 : ~shift_q[rd_idx];
                        end
                    end
                    StIgnore: sda_oe <= 1'b0;
                    default:  state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_switch_responder.sv
// Directed bench for i2c_switch_responder: bit-banged controller on an
// open-drain SDA model, with immediate-assertion checks.
module tb_i2c_switch_responder;

    localparam int Q = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic [1:0] addr_pins = 2'b00;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] switch_state;
    logic       write_strobe;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int strobe_pulses = 0;
    int strobe_cycles = 0;
    int oe_cycles = 0;
    logic strobe_prev = 1'b0;

    assign sda_line = sda_ctrl & ~sda_oe;

    i2c_switch_responder dut (
        .clk          (clk),
        .reset        (reset),
        .scl_in       (scl),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .addr_pins    (addr_pins),
        .switch_state (switch_state),
        .write_strobe (write_strobe),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        strobe_prev <= write_strobe;
        if (write_strobe) strobe_cycles <= strobe_cycles + 1;
        if (write_strobe && !strobe_prev) strobe_pulses <= strobe_pulses + 1;
        if (sda_oe) oe_cycles <= oe_cycles + 1;
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        sda_ctrl = b;
        wait_cyc(Q);
        scl = 1'b1;
        wait_cyc(Q);
        if (glitch) begin
            scl = 1'b0;
            wait_cyc(2);
            scl = 1'b1;
            wait_cyc(4);
            if (b) begin
                sda_ctrl = 1'b0;
                wait_cyc(2);
                sda_ctrl = 1'b1;
            end
        end
        wait_cyc(Q);
        scl = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit glitch, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch);
        sda_ctrl = 1'b1;
        wait_cyc(Q);
        scl = 1'b1;
        wait_cyc(Q);
        ack = sda_oe;
        wait_cyc(Q);
        scl = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        d = '0;
        for (int i = 0; i < 8; i++) begin
            sda_ctrl = 1'b1;
            wait_cyc(Q);
            scl = 1'b1;
            wait_cyc(Q);
            d = {d[6:0], sda_line};
            wait_cyc(Q);
            scl = 1'b0;
            wait_cyc(Q);
        end
        send_bit(nack, 1'b0);
    endtask

    task automatic start_c();
        sda_ctrl = 1'b1;
        wait_cyc(Q);
        scl = 1'b1;
        wait_cyc(Q);
        sda_ctrl = 1'b0;
        wait_cyc(Q);
        scl = 1'b0;
        wait_cyc(Q);
    endtask

    task automatic stop_c();
        sda_ctrl = 1'b0;
        wait_cyc(Q);
        scl = 1'b1;
        wait_cyc(Q);
        sda_ctrl = 1'b1;
        wait_cyc(Q);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         p0, c0, o0, n;

        wait_cyc(3);
        check("reset_sda_oe", int'(sda_oe), 0);
        check("reset_switch_state", int'(switch_state), 'h00);
        check("reset_write_strobe", int'(write_strobe), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        wait_cyc(10);

        // Plain write of 0x81.
        p0 = strobe_pulses;
        c0 = strobe_cycles;
        start_c();
        check("wr_busy_after_start", int'(busy), 1);
        send_byte(8'h90, 1'b0, ack);
        check("wr_addr_ack", int'(ack), 1);
        send_byte(8'h81, 1'b0, ack);
        check("wr_data_ack", int'(ack), 1);
        sda_ctrl = 1'b0;
        wait_cyc(Q);
        scl = 1'b1;
        wait_cyc(Q);
        sda_ctrl = 1'b1;
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wr_busy_stop_latency", n, 5);
        check("wr_switch_state", int'(switch_state), 'h81);
        check("wr_strobe_pulses", strobe_pulses - p0, 1);
        check("wr_strobe_cycles", strobe_cycles - c0, 1);
        wait_cyc(Q);

        // Address mismatch.
        addr_pins = 2'b01;
        p0 = strobe_pulses;
        o0 = oe_cycles;
        start_c();
        send_byte(8'h90, 1'b0, ack);
        check("mis_addr_nack", int'(ack), 0);
        send_byte(8'hFF, 1'b0, ack);
        stop_c();
        check("mis_oe_cycles", oe_cycles - o0, 0);
        check("mis_switch_state", int'(switch_state), 'h81);
        check("mis_strobe_pulses", strobe_pulses - p0, 0);
        addr_pins = 2'b00;

        // Preload 0x3C then read it back twice.
        start_c();
        send_byte(8'h90, 1'b0, ack);
        send_byte(8'h3C, 1'b0, ack);
        stop_c();
        check("rd_preload", int'(switch_state), 'h3C);
        start_c();
        send_byte(8'h91, 1'b0, ack);
        check("rd_addr_ack", int'(ack), 1);
        read_byte(1'b0, d);
        check("rd_byte0", int'(d), 'h3C);
        read_byte(1'b1, d);
        check("rd_byte1", int'(d), 'h3C);
        check("rd_oe_after_nack", int'(sda_oe), 0);
        o0 = oe_cycles;
        stop_c();
        check("rd_oe_quiet_to_stop", oe_cycles - o0, 0);
        check("rd_busy_after_stop", int'(busy), 0);

        // Repeated start after a partial byte, then an aborted byte.
        p0 = strobe_pulses;
        start_c();
        send_byte(8'h90, 1'b0, ack);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        start_c();
        check("rs_busy_held", int'(busy), 1);
        send_byte(8'h90, 1'b0, ack);
        check("rs_addr_ack", int'(ack), 1);
        send_byte(8'h55, 1'b0, ack);
        stop_c();
        check("rs_switch_state", int'(switch_state), 'h55);
        check("rs_strobe_pulses", strobe_pulses - p0, 1);
        p0 = strobe_pulses;
        start_c();
        send_byte(8'h90, 1'b0, ack);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        stop_c();
        check("abort_switch_state", int'(switch_state), 'h55);
        check("abort_strobe_pulses", strobe_pulses - p0, 0);

        // Write with short glitches on both lines.
        p0 = strobe_pulses;
        start_c();
        send_byte(8'h90, 1'b1, ack);
        check("gl_addr_ack", int'(ack), 1);
        send_byte(8'hA7, 1'b1, ack);
        check("gl_data_ack", int'(ack), 1);
        stop_c();
        check("gl_switch_state", int'(switch_state), 'hA7);
        check("gl_strobe_pulses", strobe_pulses - p0, 1);

        // Reset while the target is driving the address ACK.
        start_c();
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 4, 1'b0);
        sda_ctrl = 1'b1;
        wait_cyc(Q);
        check("rst_oe_before", int'(sda_oe), 1);
        reset = 1'b1;
        #1;
        check("rst_oe_immediate", int'(sda_oe), 0);
        check("rst_switch_state", int'(switch_state), 'h00);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(Q);
        scl = 1'b1;
        wait_cyc(Q);
        start_c();
        send_byte(8'h90, 1'b0, ack);
        check("post_rst_addr_ack", int'(ack), 1);
        send_byte(8'h0F, 1'b0, ack);
        check("post_rst_data_ack", int'(ack), 1);
        stop_c();
        check("post_rst_switch_state", int'(switch_state), 'h0F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
